// File: rtl/par2ser_pkg.sv
// par2ser_pkg: shared types and constants for the framed parallel-to-serial
// converter.
//   P2S_DATAWIDTH : bits per word (>= 2)
//   P2S_MAX_KEEP  : largest per-bit hold time in cycles (>= 1)
//   P2S_KW        : width of the keep field
//   state_t       : shifter FSM states
//   word_t        : one accepted word {data, keep_eff, msb_first}
//   clamp_keep()  : maps a raw keep request onto 1..P2S_MAX_KEEP
package par2ser_pkg;

  localparam int P2S_DATAWIDTH = 8;
  localparam int P2S_MAX_KEEP  = 16;
  localparam int P2S_KW        = $clog2(P2S_MAX_KEEP + 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  typedef struct packed {
    logic [P2S_DATAWIDTH-1:0] data;
    logic [P2S_KW-1:0]        keep;       // already clamped
    logic                     msb_first;
  } word_t;

  // A keep of 0 would mean "never advance", so it is promoted to 1.
  function automatic logic [P2S_KW-1:0] clamp_keep(input logic [P2S_KW-1:0] keep);
    if (keep == '0)
      return P2S_KW'(1);
    else if (keep > P2S_KW'(P2S_MAX_KEEP))
      return P2S_KW'(P2S_MAX_KEEP);
    else
      return keep;
  endfunction

endpackage

// File: rtl/par2ser_if.sv
// par2ser_if: word-side handshake plus serial-side outputs of par2ser_framed.
//   i_data, i_keep, i_msb_first, i_valid : word offered by the producer
//   o_ready                              : converter can take a word
//   o_data, o_valid, o_first, o_last     : framed serial stream
//   o_busy                               : shifter active or buffer occupied
// Modports: master = producer/observer side, slave = converter side.
interface par2ser_if
  import par2ser_pkg::*;
();

  logic [P2S_DATAWIDTH-1:0] i_data;
  logic [P2S_KW-1:0]        i_keep;
  logic                     i_msb_first;
  logic                     i_valid;
  logic                     o_ready;
  logic                     o_data;
  logic                     o_valid;
  logic                     o_first;
  logic                     o_last;
  logic                     o_busy;

  modport master (
    output i_data, i_keep, i_msb_first, i_valid,
    input  o_ready, o_data, o_valid, o_first, o_last, o_busy
  );

  modport slave (
    input  i_data, i_keep, i_msb_first, i_valid,
    output o_ready, o_data, o_valid, o_first, o_last, o_busy
  );

endinterface

// File: rtl/par2ser_wordbuf.sv
// par2ser_wordbuf: one-entry holding register for a word accepted while the
// shifter is still busy.
//   clk, rstn : clock, asynchronous active-low reset
//   push      : store push_word (only ever asserted while empty)
//   push_word : word record to store
//   pop       : shifter takes the stored word (only ever asserted while full)
//   ready     : registered !full, safe to use as upstream o_ready
//   full      : entry occupied
//   word      : stored word record
module par2ser_wordbuf
  import par2ser_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  logic  push,
  input  word_t push_word,
  input  logic  pop,
  output logic  ready,
  output logic  full,
  output word_t word
);

  logic  full_reg, full_next;
  logic  ready_reg;
  word_t word_reg;

  // push needs ready (= empty) and pop needs full, so they never coincide.
  always_comb begin
    full_next = full_reg;
    if (push)
      full_next = 1'b1;
    else if (pop)
      full_next = 1'b0;
  end

  // ready is kept as its own flop so o_ready has no path from i_valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full_reg  <= 1'b0;
      ready_reg <= 1'b1;
      word_reg  <= '0;
    end else begin
      full_reg  <= full_next;
      ready_reg <= !full_next;
      if (push)
        word_reg <= push_word;
    end
  end

  assign ready = ready_reg;
  assign full  = full_reg;
  assign word  = word_reg;

endmodule

// File: rtl/par2ser_framed.sv
// par2ser_framed: parallel-to-serial converter with valid/ready input,
// per-word bit order and per-bit hold time, and first/last-bit markers.
// Word width and keep limit come from par2ser_pkg.
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : par2ser_if slave (word handshake in, framed serial stream out)
module par2ser_framed
  import par2ser_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  par2ser_if.slave bus
);

  localparam int DATAWIDTH = P2S_DATAWIDTH;
  localparam int KW        = P2S_KW;
  localparam int BW        = $clog2(DATAWIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATAWIDTH - 1);

  state_t        state_reg, state_next;
  word_t         cur_reg, cur_next;
  logic [BW-1:0] bit_cnt_reg, bit_cnt_next;
  logic [KW-1:0] hold_cnt_reg, hold_cnt_next;
  logic          data_reg, data_next;
  logic          valid_reg, valid_next;
  logic          first_reg, first_next;
  logic          last_reg, last_next;

  word_t         in_word, buf_word, load_word;
  logic          in_fire, buf_ready, buf_full, buf_push, buf_pop, load;
  logic          end_of_bit, end_of_word;
  logic [BW-1:0] bit_adv;

  // Serialised position n maps to data[n] (LSB first) or data[W-1-n].
  function automatic logic pick_bit(input word_t w, input logic [BW-1:0] n);
    return w.msb_first ? w.data[LAST_BIT - n] : w.data[n];
  endfunction

  assign in_word     = '{bus.i_data, clamp_keep(bus.i_keep), bus.i_msb_first};
  assign in_fire     = bus.i_valid && buf_ready;
  assign end_of_bit  = (state_reg == S_SHIFT) && (hold_cnt_reg == cur_reg.keep - KW'(1));
  assign end_of_word = end_of_bit && (bit_cnt_reg == LAST_BIT);
  assign bit_adv     = bit_cnt_reg + BW'(1);

  par2ser_wordbuf u_wordbuf (
    .clk       (clk),
    .rstn      (rstn),
    .push      (buf_push),
    .push_word (in_word),
    .pop       (buf_pop),
    .ready     (buf_ready),
    .full      (buf_full),
    .word      (buf_word)
  );

  // Outputs are computed one cycle ahead and registered, so they only move
  // on bit or word boundaries.
  always_comb begin
    state_next    = state_reg;
    cur_next      = cur_reg;
    bit_cnt_next  = bit_cnt_reg;
    hold_cnt_next = hold_cnt_reg;
    data_next     = data_reg;
    valid_next    = valid_reg;
    first_next    = first_reg;
    last_next     = last_reg;
    buf_push      = 1'b0;
    buf_pop       = 1'b0;
    load          = 1'b0;
    load_word     = in_word;

    case (state_reg)
      S_IDLE: begin
        if (in_fire)
          load = 1'b1;
      end
      S_SHIFT: begin
        if (!end_of_bit) begin
          hold_cnt_next = hold_cnt_reg + KW'(1);
        end else if (!end_of_word) begin
          bit_cnt_next  = bit_adv;
          hold_cnt_next = '0;
          data_next     = pick_bit(cur_reg, bit_adv);
          first_next    = 1'b0;
          last_next     = (bit_adv == LAST_BIT);
        end else if (buf_full) begin
          // Buffered word wins; o_ready is low so no bypass can be pending.
          load      = 1'b1;
          load_word = buf_word;
          buf_pop   = 1'b1;
        end else if (in_fire) begin
          load = 1'b1;  // bypass straight into the shifter
        end else begin
          state_next = S_IDLE;
          data_next  = 1'b0;
          valid_next = 1'b0;
          first_next = 1'b0;
          last_next  = 1'b0;
        end
        if (in_fire && !end_of_word)
          buf_push = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase

    if (load) begin
      state_next    = S_SHIFT;
      cur_next      = load_word;
      bit_cnt_next  = '0;
      hold_cnt_next = '0;
      data_next     = pick_bit(load_word, '0);
      valid_next    = 1'b1;
      first_next    = 1'b1;
      last_next     = 1'b0;  // words are at least two bits long
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= S_IDLE;
      cur_reg      <= '0;
      bit_cnt_reg  <= '0;
      hold_cnt_reg <= '0;
      data_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      first_reg    <= 1'b0;
      last_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cur_reg      <= cur_next;
      bit_cnt_reg  <= bit_cnt_next;
      hold_cnt_reg <= hold_cnt_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      first_reg    <= first_next;
      last_reg     <= last_next;
    end
  end

  assign bus.o_ready = buf_ready;
  assign bus.o_data  = data_reg;
  assign bus.o_valid = valid_reg;
  assign bus.o_first = first_reg;
  assign bus.o_last  = last_reg;
  assign bus.o_busy  = (state_reg == S_SHIFT) || buf_full;

endmodule

// File: tb/tb_par2ser_framed.sv
// tb_par2ser_framed: directed checks of par2ser_framed. Inputs change and
// outputs are sampled on the falling edge; "cycle c" is the c-th falling edge
// after the accepting rising edge.
module tb_par2ser_framed;
  import par2ser_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  par2ser_if bus ();

  par2ser_framed dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.i_valid     = 1'b0;
    bus.i_data      = '0;
    bus.i_keep      = '0;
    bus.i_msb_first = 1'b0;
  endtask

  task automatic offer(input logic [7:0] d, input int k, input logic msb);
    bus.i_data      = d;
    bus.i_keep      = P2S_KW'(k);
    bus.i_msb_first = msb;
    bus.i_valid     = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_data  !== 1'b0) begin n_err++; $display("FAIL reset_data got %b want 0", bus.o_data); end
    n_cmp++; if (bus.o_first !== 1'b0) begin n_err++; $display("FAIL reset_first got %b want 0", bus.o_first); end
    n_cmp++; if (bus.o_last  !== 1'b0) begin n_err++; $display("FAIL reset_last got %b want 0", bus.o_last); end
    n_cmp++; if (bus.o_busy  !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
    n_cmp++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.o_ready); end
    rstn = 1'b1;
    @(negedge clk);
    $display("reset: outputs checked");
  endtask

  // {valid, data, first, last, busy} per cycle
  task automatic test_lsb_keep1();
    logic seq [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [4:0] exp_v, got_v;
    @(negedge clk);
    offer(8'h15, 1, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      got_v = {bus.o_valid, bus.o_data, bus.o_first, bus.o_last, bus.o_busy};
      exp_v = (c <= 8) ? {1'b1, seq[c-1], 1'(c == 1), 1'(c == 8), 1'b1} : 5'b00000;
      n_cmp++;
      if (got_v !== exp_v) begin n_err++; $display("FAIL lsb_keep1 cycle %0d got %b want %b", c, got_v, exp_v); end
      if (c == 1) bus.i_valid = 1'b0;
    end
    $display("word 0x15 keep 1 lsb-first: 9 cycles checked");
  endtask

  task automatic test_msb_keep3();
    logic seq [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [4:0] exp_v, got_v;
    @(negedge clk);
    offer(8'hA3, 3, 1'b1);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      got_v = {bus.o_valid, bus.o_data, bus.o_first, bus.o_last, bus.o_busy};
      exp_v = (c <= 24) ? {1'b1, seq[(c-1)/3], 1'(c <= 3), 1'(c >= 22), 1'b1} : 5'b00000;
      n_cmp++;
      if (got_v !== exp_v) begin n_err++; $display("FAIL msb_keep3 cycle %0d got %b want %b", c, got_v, exp_v); end
      if (c == 1) bus.i_valid = 1'b0;
    end
    $display("word 0xA3 keep 3 msb-first: 25 cycles checked");
  endtask

  task automatic test_back_to_back();
    logic s35 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic s12 [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [4:0] exp_v, got_v;
    logic       exp_b;
    int         pos;
    @(negedge clk);
    offer(8'h35, 2, 1'b0);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      got_v = {bus.o_valid, bus.o_data, bus.o_first, bus.o_last, bus.o_busy};
      pos   = (c - 1) % 16;
      exp_b = (c <= 16) ? s35[pos/2] : s12[pos/2];
      exp_v = (c <= 32) ? {1'b1, exp_b, 1'(pos < 2), 1'(pos >= 14), 1'b1} : 5'b00000;
      n_cmp++;
      if (got_v !== exp_v) begin n_err++; $display("FAIL b2b cycle %0d got %b want %b", c, got_v, exp_v); end
      if (c == 1 || c == 2 || c == 16 || c == 17) begin
        n_cmp++;
        if (bus.o_ready !== ((c == 1 || c == 17) ? 1'b1 : 1'b0))
          begin n_err++; $display("FAIL b2b_ready cycle %0d got %b want %b", c, bus.o_ready, (c == 1 || c == 17)); end
      end
      if (c == 1) bus.i_data = 8'h12;
      if (c == 2) bus.i_valid = 1'b0;
    end
    $display("words 0x35,0x12 keep 2 back-to-back: 33 cycles checked");
  endtask

  task automatic test_keep_bounds();
    logic s15 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic sc1 [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [4:0] exp_v, got_v;
    // keep 0 behaves as keep 1
    @(negedge clk);
    offer(8'h15, 0, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      got_v = {bus.o_valid, bus.o_data, bus.o_first, bus.o_last, bus.o_busy};
      exp_v = (c <= 8) ? {1'b1, s15[c-1], 1'(c == 1), 1'(c == 8), 1'b1} : 5'b00000;
      n_cmp++;
      if (got_v !== exp_v) begin n_err++; $display("FAIL keep0 cycle %0d got %b want %b", c, got_v, exp_v); end
      if (c == 1) bus.i_valid = 1'b0;
    end
    $display("word 0x15 keep 0 lsb-first: 9 cycles checked");
    // keep MAX_KEEP+5 saturates to MAX_KEEP (16): 128 valid cycles
    @(negedge clk);
    offer(8'hC1, P2S_MAX_KEEP + 5, 1'b1);
    for (int c = 1; c <= 129; c++) begin
      @(negedge clk);
      got_v = {bus.o_valid, bus.o_data, bus.o_first, bus.o_last, bus.o_busy};
      exp_v = (c <= 128) ? {1'b1, sc1[(c-1)/16], 1'(c <= 16), 1'(c >= 113), 1'b1} : 5'b00000;
      n_cmp++;
      if (got_v !== exp_v) begin n_err++; $display("FAIL keep_sat cycle %0d got %b want %b", c, got_v, exp_v); end
      if (c == 1) bus.i_valid = 1'b0;
    end
    $display("word 0xC1 keep 21 msb-first: 129 cycles checked");
  endtask

  task automatic test_bypass();
    logic [4:0] exp_v, got_v;
    @(negedge clk);
    offer(8'hFF, 1, 1'b0);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      got_v = {bus.o_valid, bus.o_data, bus.o_first, bus.o_last, bus.o_busy};
      if (c <= 8)
        exp_v = {1'b1, 1'b1, 1'(c == 1), 1'(c == 8), 1'b1};
      else if (c <= 16)
        exp_v = {1'b1, 1'b0, 1'(c == 9), 1'(c == 16), 1'b1};
      else
        exp_v = 5'b00000;
      n_cmp++;
      if (got_v !== exp_v) begin n_err++; $display("FAIL bypass cycle %0d got %b want %b", c, got_v, exp_v); end
      if (c == 9) begin
        n_cmp++;
        if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL bypass_ready got %b want 1", bus.o_ready); end
      end
      if (c == 1) bus.i_valid = 1'b0;
      if (c == 8) offer(8'h00, 1, 1'b0);  // offered on the last-bit cycle
      if (c == 9) bus.i_valid = 1'b0;
    end
    $display("words 0xFF,0x00 keep 1 bypass: 17 cycles checked");
  endtask

  task automatic test_reset_mid();
    logic seq [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [5:0] got_r;
    @(negedge clk);
    offer(8'h5A, 1, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.o_valid, bus.o_data} !== {1'b1, seq[c-1]})
        begin n_err++; $display("FAIL rst_mid_pre cycle %0d got %b%b want 1%b", c, bus.o_valid, bus.o_data, seq[c-1]); end
      if (c == 1) bus.i_valid = 1'b0;
    end
    rstn = 1'b0;  // during bit 4, away from any rising edge
    #1;
    got_r = {bus.o_valid, bus.o_data, bus.o_first, bus.o_last, bus.o_busy, bus.o_ready};
    n_cmp++;
    if (got_r !== 6'b000001) begin n_err++; $display("FAIL rst_mid_async got %b want 000001", got_r); end
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      got_r = {bus.o_valid, bus.o_data, bus.o_first, bus.o_last, bus.o_busy, bus.o_ready};
      n_cmp++;
      if (got_r !== 6'b000001) begin n_err++; $display("FAIL rst_mid_after cycle %0d got %b want 000001", c, got_r); end
    end
    $display("word 0x5A reset mid-word: checked");
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_lsb_keep1();
    test_msb_keep3();
    test_back_to_back();
    test_keep_bounds();
    test_bypass();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/par2ser_framed.md
Name: par2ser_framed

Overview:
- Parallel-to-serial converter with a valid/ready input handshake, runtime-selectable bit order, and a runtime-selectable per-bit hold time.
- Sits between a word-producing block and a slow single-wire consumer.
- A one-entry word buffer allows back-to-back words with no idle cycle between them.
- Adds first/last-bit markers so downstream logic can frame words.

Parameters:
- DATAWIDTH, 8: bits per word; must be ≥ 2.
- MAX_KEEP, 16: maximum cycles each bit is held; must be ≥ 1.
- KW, $clog2(MAX_KEEP+1): width of the keep field (localparam).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rstn  in  1  reset, asynchronous, active-low.
- i_data  in  DATAWIDTH  parallel word.
- i_keep  in  KW  hold cycles per bit, sampled with the word. Value 0 is treated as 1. Values above MAX_KEEP saturate to MAX_KEEP.
- i_msb_first  in  1  bit order for the word, sampled with the word (1 = MSB first).
- i_valid  in  1  word offered.
- o_ready  out  1  block can accept a word this cycle.
- o_data  out  1  serial bit.
- o_valid  out  1  o_data is meaningful.
- o_first  out  1  o_data is bit 0 of the serialised sequence.
- o_last  out  1  o_data is the final bit of the word.
- o_busy  out  1  shifter active or buffer occupied.

Behaviour:
- Reset (asynchronous, active-low). All registers clear immediately. Outputs go to o_valid=0, o_data=0, o_first=0, o_last=0, o_busy=0, o_ready=1. Any word in flight or buffered is discarded. Reset takes effect mid-word, and nothing resumes after release.
- Handshake. A transfer occurs on a rising edge where i_valid && o_ready. o_ready = !buf_full and is driven directly from a register, with no combinational path from i_valid. i_data, i_keep and i_msb_first are sampled together on the accepting edge.
- Word record. Each accepted word is stored as {data, keep_eff, msb_first}, where keep_eff = clamp(i_keep, 1, MAX_KEEP).
- State IDLE (shifter empty):
  - An accepted word loads straight into the shifter and the state goes to SHIFT.
  - Latency: accepting edge T, first bit on o_data with o_valid=1 and o_first=1 in the cycle after T.
- State SHIFT:
  - Each bit is driven for exactly keep_eff consecutive cycles with o_valid=1.
  - o_first is high for all keep_eff cycles of the first bit. o_last is high for all keep_eff cycles of the final bit.
  - Bit index advances from 0 up (LSB first) or from DATAWIDTH-1 down (MSB first).
  - The hold counter counts 0..keep_eff-1. The bit counter counts 0..DATAWIDTH-1.
  - A new word accepted during SHIFT goes into the buffer, which sets buf_full and drops o_ready.
- End of word (last cycle of the last bit):
  - If buf_full: the buffer moves to the shifter, and the next word's first bit appears in the very next cycle with no o_valid gap. buf_full clears, so o_ready returns high one cycle later.
  - Else, if a word is accepted on that same edge: it bypasses the buffer and loads straight into the shifter, again with no gap.
  - Else: go to IDLE, and o_valid=0 from the next cycle.
- Simultaneous events. When the buffer is full, o_ready=0, so acceptance and drain never collide in the buffer. Buffer-to-shifter transfer takes priority over bypass.
- Throughput. A sustained stream gives DATAWIDTH*keep_eff cycles per word with o_valid continuously high.
- Output stability. o_data, o_first, o_last and o_valid are registered outputs. They change only at bit boundaries or word boundaries.

Decomposition:
- Package par2ser_pkg holds:
  - typedef enum logic {S_IDLE, S_SHIFT} state_t;
  - the word-record struct (data, keep, msb_first), parameterised through localparams;
  - the keep clamp function.
- Sub-module par2ser_wordbuf is the one-entry buffer with registered ready and a pop input. The top level holds the FSM, shifter and counters.

Test Plan:
- Single word, LSB first, keep 1: i_data=8'h15, i_keep=1, i_msb_first=0 → one cycle after acceptance, o_data over 8 cycles = 1,0,1,0,1,0,0,0. o_first on cycle 1 and o_last on cycle 8. o_valid=0 on cycle 9.
- MSB first, keep 3: i_data=8'hA3, i_keep=3, i_msb_first=1 → each bit held 3 cycles, sequence 1,0,1,0,0,0,1,1. o_valid is high for 24 cycles. o_first is high for the first 3 cycles and o_last for the final 3.
- Back-to-back words:
  - Stimulus: i_valid held high with 8'h35 then 8'h12, keep 2.
  - Response: the second word is accepted during the first word's serialisation and o_ready drops until the buffer drains. o_valid stays high for 32 contiguous cycles, and o_first re-asserts on cycle 17.
- Keep boundaries: i_keep=0 → behaves as keep 1. i_keep=MAX_KEEP+5 (within KW) → each bit held MAX_KEEP cycles.
- Bypass at end of word:
  - Stimulus: word 8'hFF, keep 1. The second word 8'h00 is offered exactly on the last-bit cycle.
  - Response: it is accepted on that edge, the next cycle shows o_data=0 with o_first=1, and there is no o_valid gap.
- Reset mid-word: assert rstn=0 during bit 4 of 8'h5A → o_valid, o_data and o_busy go to 0 immediately, with o_ready=1. After release there is no output until a new word is accepted.
